// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch sequencer owning the PC and the instruction-memory request handshake
// Optional feature macro: PC_ALIGN_CHECK_EN (reject misaligned redirect targets, pulse o_misalign)
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  input  logic        i_exception,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  output logic        o_fetch_valid,
  output logic [31:0] o_fetch_pc,
  output logic        o_misalign
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, STALL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic        kill_q, kill_d;
  logic        fv_q, fv_d;
  logic [31:0] fpc_q, fpc_d;
  logic        mis_q, mis_d;

  logic        redir_ok;
  logic [31:0] redir_tgt;
  logic        mis_evt;
  logic        evt;
  logic [31:0] evt_tgt;

`ifdef PC_ALIGN_CHECK_EN
  // Misaligned redirects are dropped; an exception in the same cycle wins anyway.
  assign redir_ok  = i_redirect_valid && (i_redirect_target[1:0] == 2'b00);
  assign redir_tgt = i_redirect_target;
  assign mis_evt   = i_redirect_valid && !i_exception && (i_redirect_target[1:0] != 2'b00);
`else
  // Low address bits are simply forced to word alignment.
  assign redir_ok  = i_redirect_valid;
  assign redir_tgt = i_redirect_target & 32'hFFFF_FFFC;
  assign mis_evt   = 1'b0;
`endif

  assign evt     = i_exception || redir_ok;
  assign evt_tgt = i_exception ? EXC_VECTOR : redir_tgt;

  assign o_imem_req    = (state_q == FETCH) || (state_q == WAIT);
  assign o_imem_addr   = pc_q;
  assign o_fetch_valid = fv_q;
  assign o_fetch_pc    = fpc_q;
  assign o_misalign    = mis_q;

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_VECTOR;
      pend_q   <= 32'h0;
      pend_v_q <= 1'b0;
      kill_q   <= 1'b0;
      fv_q     <= 1'b0;
      fpc_q    <= 32'h0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      kill_q   <= kill_d;
      fv_q     <= fv_d;
      fpc_q    <= fpc_d;
      mis_q    <= mis_d;
    end
  end

  // Next-state, next-PC selection and completion bookkeeping.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    kill_d   = kill_q;
    fv_d     = 1'b0;
    fpc_d    = fpc_q;
    mis_d    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = i_stall ? STALL : FETCH;
      end
      FETCH, WAIT: begin
        mis_d = mis_evt;
        if (i_imem_ack) begin
          fv_d = !(evt || kill_q);
          if (!(evt || kill_q)) fpc_d = pc_q;
          if (evt)           pc_d = evt_tgt;
          else if (pend_v_q) pc_d = pend_q;
          else               pc_d = pc_q + 32'd4;
          pend_v_d = 1'b0;
          kill_d   = 1'b0;
          state_d  = i_stall ? STALL : FETCH;
        end else begin
          // Request stays up; a redirect seen now is applied when it completes.
          if (evt) begin
            pend_d   = evt_tgt;
            pend_v_d = 1'b1;
            kill_d   = 1'b1;
          end
          state_d = WAIT;
        end
      end
      STALL: begin
        mis_d = mis_evt;
        if (evt) pc_d = evt_tgt;
        if (!i_stall) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
